// File: rtl/mcs4_pkg.sv
// mcs4_pkg
// Shared definitions for the MCS-4 ROM bus interface:
//   phase_t  - 8-phase instruction-cycle encoding plus an IDLE state
//   io_op_t  - pending ROM I/O operation decoded in M2
//   OPR_IO / OPA_WRR / OPA_RDR - opcode nibbles for the ROM port instructions
//   next_phase_of() - free-running phase advance (no resync)
package mcs4_pkg;

    typedef enum logic [3:0] {
        PH_IDLE,
        PH_A1,
        PH_A2,
        PH_A3,
        PH_M1,
        PH_M2,
        PH_X1,
        PH_X2,
        PH_X3
    } phase_t;

    typedef enum logic [1:0] {
        IO_NONE,
        IO_WRR,
        IO_RDR
    } io_op_t;

    localparam logic [3:0] OPR_IO  = 4'hE;
    localparam logic [3:0] OPA_WRR = 4'h2;
    localparam logic [3:0] OPA_RDR = 4'hA;

    // IDLE is sticky: only SYNC_N can move the bus out of it.
    function automatic phase_t next_phase_of(input phase_t p);
        phase_t n;
        case (p)
            PH_A1:   n = PH_A2;
            PH_A2:   n = PH_A3;
            PH_A3:   n = PH_M1;
            PH_M1:   n = PH_M2;
            PH_M2:   n = PH_X1;
            PH_X1:   n = PH_X2;
            PH_X2:   n = PH_X3;
            PH_X3:   n = PH_A1;
            default: n = PH_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mcs4_phase_ctr.sv
// mcs4_phase_ctr
// Tracks the CPU's 8-phase instruction cycle from the SYNC_N pin.
// Ports:
//   clk    in   system clock, one bus phase per cycle
//   res    in   synchronous active-high reset
//   sync_n in   CPU sync, low for one cycle during X3
//   phase  out  current bus phase (PH_IDLE after reset)
//   synced out  set once the first SYNC_N has been seen
module mcs4_phase_ctr
    import mcs4_pkg::*;
(
    input  logic   clk,
    input  logic   res,
    input  logic   sync_n,
    output phase_t phase,
    output logic   synced
);

    phase_t phase_q;
    phase_t phase_d;

    // Phase register and sticky synced flag.
    always_ff @(posedge clk) begin
        if (res) begin
            phase_q <= PH_IDLE;
            synced  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (!sync_n) begin
                synced <= 1'b1;
            end
        end
    end

    // A low SYNC_N realigns us to A1 from any phase, even mid-cycle.
    always_comb begin
        phase_d = next_phase_of(phase_q);
        if (!sync_n) begin
            phase_d = PH_A1;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/mcs4_rom_bus_if.sv
// mcs4_rom_bus_if
// Target-side 4001 ROM interface on the MCS-4 CPU bus: captures the fetch
// address, reads program memory, returns OPR/OPA, and executes SRC/WRR/RDR
// for up to NCHIP ROM chips.
// Ports:
//   CLK, RES    clock / synchronous active-high reset
//   SYNC_N      CPU sync (low during X3)
//   CM_ROM_N    CPU ROM command line
//   DATA_IN     data bus as seen at the pins
//   DATA_OUT    value to drive on the data bus
//   DATA_OE     data bus drive enable (1 = drive)
//   ROM_ADDR    program memory read address
//   ROM_RE      program memory read strobe (A3)
//   ROM_RDATA   program memory byte, valid the cycle after ROM_RE
//   IN_PORT     chip n input pins at [4n+3:4n]
//   OUT_PORT    chip n output latches at [4n+3:4n]
//   SYNCED      1 once the first SYNC_N has been seen
module mcs4_rom_bus_if
    import mcs4_pkg::*;
#(
    parameter int NCHIP  = 16,
    parameter int ROM_AW = 12
) (
    input  logic                 CLK,
    input  logic                 RES,
    input  logic                 SYNC_N,
    input  logic                 CM_ROM_N,
    input  logic [3:0]           DATA_IN,
    output logic [3:0]           DATA_OUT,
    output logic                 DATA_OE,
    output logic [ROM_AW-1:0]    ROM_ADDR,
    output logic                 ROM_RE,
    input  logic [7:0]           ROM_RDATA,
    input  logic [4*NCHIP-1:0]   IN_PORT,
    output logic [4*NCHIP-1:0]   OUT_PORT,
    output logic                 SYNCED
);

    phase_t             phase;
    logic [11:0]        addr_q;
    logic [11:0]        fetch_addr;
    logic               fetch_en;
    logic [7:0]         rom_byte;
    io_op_t             io_pending;
    logic [3:0]         src_chip;
    logic [4*NCHIP-1:0] out_port_q;
    logic [3:0]         in_nibble;
    logic               chip_hit;

    mcs4_phase_ctr u_phase (
        .clk    (CLK),
        .res    (RES),
        .sync_n (SYNC_N),
        .phase  (phase),
        .synced (SYNCED)
    );

    // Selected chip's input nibble; chip_hit stays 0 for chips >= NCHIP.
    always_comb begin
        in_nibble = 4'h0;
        chip_hit  = 1'b0;
        for (int n = 0; n < NCHIP; n++) begin
            if (src_chip == 4'(n)) begin
                in_nibble = IN_PORT[4*n +: 4];
                chip_hit  = 1'b1;
            end
        end
    end

    // Address capture, opcode latch, I/O decode and port latches.
    always_ff @(posedge CLK) begin
        if (RES) begin
            addr_q     <= 12'h000;
            fetch_en   <= 1'b0;
            rom_byte   <= 8'h00;
            io_pending <= IO_NONE;
            src_chip   <= 4'h0;
            out_port_q <= '0;
        end else begin
            case (phase)
                PH_A1: addr_q[3:0] <= DATA_IN;
                PH_A2: addr_q[7:4] <= DATA_IN;
                PH_A3: begin
                    addr_q[11:8] <= DATA_IN;
                    fetch_en     <= ~CM_ROM_N;
                end
                PH_M1: rom_byte <= ROM_RDATA;
                PH_M2: begin
                    if (!CM_ROM_N && rom_byte[7:4] == OPR_IO && rom_byte[3:0] == OPA_WRR) begin
                        io_pending <= IO_WRR;
                    end else if (!CM_ROM_N && rom_byte[7:4] == OPR_IO && rom_byte[3:0] == OPA_RDR) begin
                        io_pending <= IO_RDR;
                    end else begin
                        io_pending <= IO_NONE;
                    end
                end
                PH_X2: begin
                    // SRC only when this cycle is not already a ROM I/O op.
                    if (io_pending == IO_NONE && !CM_ROM_N) begin
                        src_chip <= DATA_IN;
                    end
                    if (io_pending == IO_WRR) begin
                        for (int n = 0; n < NCHIP; n++) begin
                            if (src_chip == 4'(n)) begin
                                out_port_q[4*n +: 4] <= DATA_IN;
                            end
                        end
                    end
                end
                PH_X3: io_pending <= IO_NONE;
                default: ;
            endcase
            if (!SYNC_N) begin
                io_pending <= IO_NONE;
            end
        end
    end

    // The A3 nibble is bypassed so the read is issued in the same phase.
    always_comb begin
        fetch_addr = addr_q;
        if (phase == PH_A3) begin
            fetch_addr = {DATA_IN, addr_q[7:0]};
        end
    end

    assign ROM_ADDR = fetch_addr[ROM_AW-1:0];
    assign ROM_RE   = (phase == PH_A3) && !RES;
    assign OUT_PORT = out_port_q;

    // Bus drive: only M1/M2 (fetch) and X2 (RDR); released at once under RES.
    always_comb begin
        DATA_OUT = 4'h0;
        DATA_OE  = 1'b0;
        if (!RES) begin
            case (phase)
                PH_M1: if (fetch_en) begin
                    DATA_OUT = ROM_RDATA[7:4];
                    DATA_OE  = 1'b1;
                end
                PH_M2: if (fetch_en) begin
                    DATA_OUT = rom_byte[3:0];
                    DATA_OE  = 1'b1;
                end
                PH_X2: if (io_pending == IO_RDR && chip_hit) begin
                    DATA_OUT = in_nibble;
                    DATA_OE  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcs4_rom_bus_if.sv
// tb_mcs4_rom_bus_if
// Drives whole MCS-4 instruction cycles into two copies of the ROM bus
// interface (NCHIP = 16 and NCHIP = 4) sharing one bus and one program memory.
// Expected bus values are queued per phase and compared on the falling edge.
module tb_mcs4_rom_bus_if;

    logic        clk;
    logic        res;
    logic        sync_n;
    logic        cm_rom_n;
    logic [3:0]  data_in;
    logic [7:0]  rom_rdata;
    logic [63:0] in_port;

    logic [3:0]  data_out16;
    logic        data_oe16;
    logic [11:0] rom_addr16;
    logic        rom_re16;
    logic [63:0] out_port16;
    logic        synced16;

    logic [3:0]  data_out4;
    logic        data_oe4;
    logic [11:0] rom_addr4;
    logic        rom_re4;
    logic [15:0] out_port4;
    logic        synced4;

    logic [7:0]  mem [0:4095];

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        string       tag;
        logic        oe;
        logic [3:0]  out;
        logic        re;
        logic [11:0] addr;
        logic        oe4;
    } exp_t;

    exp_t sb[$];

    mcs4_rom_bus_if #(.NCHIP(16), .ROM_AW(12)) dut16 (
        .CLK       (clk),
        .RES       (res),
        .SYNC_N    (sync_n),
        .CM_ROM_N  (cm_rom_n),
        .DATA_IN   (data_in),
        .DATA_OUT  (data_out16),
        .DATA_OE   (data_oe16),
        .ROM_ADDR  (rom_addr16),
        .ROM_RE    (rom_re16),
        .ROM_RDATA (rom_rdata),
        .IN_PORT   (in_port),
        .OUT_PORT  (out_port16),
        .SYNCED    (synced16)
    );

    mcs4_rom_bus_if #(.NCHIP(4), .ROM_AW(12)) dut4 (
        .CLK       (clk),
        .RES       (res),
        .SYNC_N    (sync_n),
        .CM_ROM_N  (cm_rom_n),
        .DATA_IN   (data_in),
        .DATA_OUT  (data_out4),
        .DATA_OE   (data_oe4),
        .ROM_ADDR  (rom_addr4),
        .ROM_RE    (rom_re4),
        .ROM_RDATA (rom_rdata),
        .IN_PORT   (in_port[15:0]),
        .OUT_PORT  (out_port4),
        .SYNCED    (synced4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program memory: byte appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rom_re16) begin
            rom_rdata <= mem[rom_addr16];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: one queued expectation per checked bus phase.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput({e.tag, "_oe"}, {63'h0, data_oe16}, {63'h0, e.oe});
            if (e.oe) checkOutput({e.tag, "_dout"}, {60'h0, data_out16}, {60'h0, e.out});
            checkOutput({e.tag, "_re"}, {63'h0, rom_re16}, {63'h0, e.re});
            if (e.re) checkOutput({e.tag, "_addr"}, {52'h0, rom_addr16}, {52'h0, e.addr});
            checkOutput({e.tag, "_oe4"}, {63'h0, data_oe4}, {63'h0, e.oe4});
            if (e.oe4) checkOutput({e.tag, "_dout4"}, {60'h0, data_out4}, {60'h0, e.out});
        end
    end

    task automatic stepPhase(input logic res_v, input logic sn_v, input logic cm_v,
                             input logic [3:0] din_v, input bit chk, input string tag,
                             input logic oe_v, input logic [3:0] out_v, input logic re_v,
                             input logic [11:0] addr_v, input logic oe4_v);
        exp_t e;
        @(posedge clk);
        #1;
        res      = res_v;
        sync_n   = sn_v;
        cm_rom_n = cm_v;
        data_in  = din_v;
        if (chk) begin
            e.tag  = tag;
            e.oe   = oe_v;
            e.out  = out_v;
            e.re   = re_v;
            e.addr = addr_v;
            e.oe4  = oe4_v;
            sb.push_back(e);
        end
    endtask

    // One instruction cycle; sync_at / res_at cut it short at that phase index.
    task automatic applyStimulus(input string tag, input logic [11:0] addr,
                                 input logic cm_a3, input logic cm_m2, input logic cm_x2,
                                 input logic [3:0] x2_din, input logic x2_oe,
                                 input logic [3:0] x2_out, input logic x2_oe4,
                                 input int sync_at, input int res_at);
        logic [7:0] b;
        logic       fe;
        logic       sn;
        logic       rv;
        b  = mem[addr];
        fe = ~cm_a3;
        for (int p = 0; p < 8; p++) begin
            sn = (p == sync_at) ? 1'b0 : 1'b1;
            rv = (p == res_at) ? 1'b1 : 1'b0;
            case (p)
                0: stepPhase(rv, sn, 1'b1, addr[3:0], !rv, {tag, "_A1"}, 1'b0, 4'h0, 1'b0, 12'h0, 1'b0);
                1: stepPhase(rv, sn, 1'b1, addr[7:4], !rv, {tag, "_A2"}, 1'b0, 4'h0, 1'b0, 12'h0, 1'b0);
                2: stepPhase(rv, sn, cm_a3, addr[11:8], !rv, {tag, "_A3"}, 1'b0, 4'h0, 1'b1, addr, 1'b0);
                3: stepPhase(rv, sn, 1'b1, 4'h0, !rv, {tag, "_M1"}, fe, b[7:4], 1'b0, 12'h0, fe);
                4: stepPhase(rv, sn, cm_m2, 4'h0, !rv, {tag, "_M2"}, fe, b[3:0], 1'b0, 12'h0, fe);
                5: stepPhase(rv, sn, 1'b1, 4'h0, !rv, {tag, "_X1"}, 1'b0, 4'h0, 1'b0, 12'h0, 1'b0);
                6: stepPhase(rv, sn, cm_x2, x2_din, !rv, {tag, "_X2"}, x2_oe, x2_out, 1'b0, 12'h0, x2_oe4);
                default: stepPhase(rv, sn, 1'b1, 4'h0, !rv, {tag, "_X3"}, 1'b0, 4'h0, 1'b0, 12'h0, 1'b0);
            endcase
            if (p == sync_at || p == res_at) break;
        end
    endtask

    task automatic syncUp(input string tag);
        stepPhase(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, tag, 1'b0, 4'h0, 1'b0, 12'h0, 1'b0);
    endtask

    task automatic checkState(input string tag, input logic [63:0] o16, input logic [15:0] o4, input logic s);
        @(negedge clk);
        #1;
        checkOutput({tag, "_out16"}, out_port16, o16);
        checkOutput({tag, "_out4"}, {48'h0, out_port4}, {48'h0, o4});
        checkOutput({tag, "_synced"}, {63'h0, synced16}, {63'h0, s});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h234] = 8'hD7;
        mem[12'h235] = 8'h21;
        mem[12'h236] = 8'hE2;
        mem[12'h237] = 8'hEA;
        mem[12'h238] = 8'h27;
        mem[12'h239] = 8'hE2;
        mem[12'h23A] = 8'hEA;
        mem[12'h23B] = 8'h25;
        mem[12'h23C] = 8'hE2;
        mem[12'h23D] = 8'hEA;
        mem[12'h23E] = 8'hEA;
        mem[12'h240] = 8'h5A;
        mem[12'h241] = 8'hE2;
        rom_rdata = 8'h00;
        in_port   = 64'h0000_0000_3090_0400;
        res       = 1'b1;
        sync_n    = 1'b1;
        cm_rom_n  = 1'b1;
        data_in   = 4'h0;

        // Reset state
        repeat (3) stepPhase(1'b1, 1'b1, 1'b1, 4'h0, 1'b0, "rst", 1'b0, 4'h0, 1'b0, 12'h0, 1'b0);
        stepPhase(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, "idle0", 1'b0, 4'h0, 1'b0, 12'h0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("rst_dout", {60'h0, data_out16}, 64'h0);
        checkOutput("rst_addr", {52'h0, rom_addr16}, 64'h0);
        checkOutput("rst_out16", out_port16, 64'h0);
        checkOutput("rst_synced", {63'h0, synced16}, 64'h0);

        // Plain fetch, then SRC/WRR/RDR on chips 5, 7 and 2
        syncUp("sync1");
        applyStimulus("c1_fetch", 12'h234, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 7, -1);
        checkState("c1", 64'h0, 16'h0, 1'b1);
        applyStimulus("c2_src5", 12'h235, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 4'h0, 1'b0, 7, -1);
        applyStimulus("c3_wrr", 12'h236, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 7, -1);
        checkState("c3", 64'h0000_0000_00A0_0000, 16'h0000, 1'b1);
        applyStimulus("c4_rdr", 12'h237, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 4'h9, 1'b0, 7, -1);
        applyStimulus("c5_src7", 12'h238, 1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 4'h0, 1'b0, 7, -1);
        applyStimulus("c6_wrr", 12'h239, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 7, -1);
        checkState("c6", 64'h0000_0000_F0A0_0000, 16'h0000, 1'b1);
        applyStimulus("c7_rdr", 12'h23A, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 4'h3, 1'b0, 7, -1);
        applyStimulus("c8_src2", 12'h23B, 1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 4'h0, 1'b0, 7, -1);
        applyStimulus("c9_wrr", 12'h23C, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 4'h0, 1'b0, 7, -1);
        checkState("c9", 64'h0000_0000_F0A0_0600, 16'h0600, 1'b1);
        applyStimulus("c10_rdr", 12'h23D, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 4'h4, 1'b1, 7, -1);

        // Suppressed fetch, and an E2 byte without CM_ROM_N in M2
        applyStimulus("c11_nofetch", 12'h240, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 7, -1);
        applyStimulus("c12_nocm", 12'h241, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 7, -1);
        checkState("c12", 64'h0000_0000_F0A0_0600, 16'h0600, 1'b1);

        // Resync at M1, then a normal cycle must follow from A1
        applyStimulus("c13_resync", 12'h23E, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3, -1);
        applyStimulus("c14_after", 12'h234, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 7, -1);

        // RES during M2
        applyStimulus("c15_res", 12'h23D, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 7, 4);
        stepPhase(1'b0, 1'b1, 1'b1, 4'h0, 1'b1, "post_res", 1'b0, 4'h0, 1'b0, 12'h0, 1'b0);
        checkState("post_res", 64'h0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepPhase(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'b1, $sformatf("idle_%0d", i),
                      1'b0, 4'h0, 1'b0, 12'h0, 1'b0);
        end

        // Recovery: src_chip is back to 0, so RDR returns chip 0's pins
        syncUp("sync2");
        applyStimulus("c16_fetch", 12'h234, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 7, -1);
        checkState("c16", 64'h0, 16'h0, 1'b1);
        applyStimulus("c17_rdr0", 12'h23D, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 7, -1);

        repeat (2) @(negedge clk);
        #1;
        checkOutput("sb_drain", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
